// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the IF/EXE memory request arbiter: owner tags,
// access size encodings and the default outstanding-request depth.
package mem_req_arbiter_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int unsigned DEF_OUTSTANDING = 4;
    localparam int unsigned DEF_TAG_PTR_W   = $clog2(DEF_OUTSTANDING);

endpackage

// File: rtl/mem_req_arbiter_owner_tag_fifo.sv
// In-order FIFO of 1-bit owner tags, one entry per accepted-but-unanswered
// memory request; the head tag steers the next bus response.
module owner_tag_fifo
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_OUTSTANDING,
    parameter int unsigned PTR_W = DEF_TAG_PTR_W
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_push,
    input  owner_e i_tag,
    input  logic   i_pop,
    output logic   o_full,
    output logic   o_empty,
    output owner_e o_head
);

    owner_e           r_tags [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_tags[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // DEPTH is a power of two, so pointer wrap is plain binary rollover.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_tags[i] <= OWNER_INST;
            end
        end else begin
            if (w_do_push) begin
                r_tags[r_wr_ptr] <= i_tag;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like port between IF (inst) and EXE (data) requesters.
// Define MEM_ARB_RR_EN for round-robin on contention (default: DATA priority).
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING = DEF_OUTSTANDING,
    parameter int unsigned TAG_PTR_W   = DEF_TAG_PTR_W
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    logic   r_lock;
    owner_e r_lock_owner;
`ifdef MEM_ARB_RR_EN
    owner_e r_rr_last;
`endif

    logic   w_full;
    logic   w_empty;
    owner_e w_head;
    logic   w_grant_vld;
    owner_e w_grant_owner;
    logic   w_accept;
    logic   w_pop;

    // Full uses the registered count, so a same-cycle pop never reopens the port.
    always_comb begin
        w_grant_vld   = 1'b0;
        w_grant_owner = OWNER_DATA;
        if (!reset && !w_full) begin
            if (r_lock) begin
                w_grant_owner = r_lock_owner;
                w_grant_vld   = (r_lock_owner == OWNER_DATA) ? data_sram_req : inst_sram_req;
            end else if (inst_sram_req && data_sram_req) begin
                w_grant_vld = 1'b1;
`ifdef MEM_ARB_RR_EN
                w_grant_owner = (r_rr_last == OWNER_INST) ? OWNER_DATA : OWNER_INST;
`else
                w_grant_owner = OWNER_DATA;
`endif
            end else if (data_sram_req) begin
                w_grant_vld   = 1'b1;
                w_grant_owner = OWNER_DATA;
            end else if (inst_sram_req) begin
                w_grant_vld   = 1'b1;
                w_grant_owner = OWNER_INST;
            end
        end
    end

    always_comb begin
        bus_req   = w_grant_vld;
        bus_wr    = 1'b0;
        bus_size  = '0;
        bus_wstrb = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        if (w_grant_vld) begin
            if (w_grant_owner == OWNER_DATA) begin
                bus_wr    = data_sram_wr;
                bus_size  = data_sram_size;
                bus_wstrb = data_sram_wstrb;
                bus_addr  = data_sram_addr;
                bus_wdata = data_sram_wdata;
            end else begin
                bus_size  = inst_sram_size;
                bus_addr  = inst_sram_addr;
            end
        end
    end

    assign w_accept          = bus_req & bus_addr_ok;
    assign inst_sram_addr_ok = w_accept & (w_grant_owner == OWNER_INST);
    assign data_sram_addr_ok = w_accept & (w_grant_owner == OWNER_DATA);

    // A response with nothing outstanding is dropped rather than popped.
    assign w_pop             = bus_data_ok & ~w_empty & ~reset;
    assign inst_sram_data_ok = w_pop & (w_head == OWNER_INST);
    assign data_sram_data_ok = w_pop & (w_head == OWNER_DATA);
    assign inst_sram_rdata   = inst_sram_data_ok ? bus_rdata : '0;
    assign data_sram_rdata   = data_sram_data_ok ? bus_rdata : '0;

    owner_tag_fifo #(
        .DEPTH (OUTSTANDING),
        .PTR_W (TAG_PTR_W)
    ) u_owner_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_tag   (w_grant_owner),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock       <= 1'b0;
            r_lock_owner <= OWNER_DATA;
        end else if (bus_req) begin
            if (bus_addr_ok) begin
                r_lock <= 1'b0;
            end else begin
                r_lock       <= 1'b1;
                r_lock_owner <= w_grant_owner;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_last <= OWNER_INST;
        end else if (w_accept) begin
            r_rr_last <= w_grant_owner;
        end
    end
`endif

`ifdef MEM_ARB_PROTOCOL_CHECKS
    a_no_stray_response: assert property (@(posedge clk) disable iff (reset)
        !(bus_data_ok && w_empty));
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: directed stimulus queues expected
// grants/responses; a negedge monitor pops and compares them.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .OUTSTANDING (4),
        .TAG_PTR_W   (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .bus_req           (bus_req),
        .bus_wr            (bus_wr),
        .bus_size          (bus_size),
        .bus_wstrb         (bus_wstrb),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_addr_ok       (bus_addr_ok),
        .bus_data_ok       (bus_data_ok),
        .bus_rdata         (bus_rdata)
    );

    // Owner as seen on the {inst, data} strobe pair.
    localparam logic [1:0] W_INST = 2'b10;
    localparam logic [1:0] W_DATA = 2'b01;

    typedef struct {
        logic [1:0]  who;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        logic [1:0]  who;
        logic [31:0] rdata;
    } resp_t;

    grant_t q_grant[$];
    resp_t  q_resp[$];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_g(input logic [1:0] who, input logic [31:0] addr, input logic wr,
                         input logic [3:0] ws, input logic [31:0] wd);
        grant_t g;
        g = '{who, addr, 2'd2, wr, ws, wd};
        q_grant.push_back(g);
    endtask

    task automatic respond(input logic [1:0] who, input logic [31:0] d);
        resp_t r;
        r = '{who, d};
        q_resp.push_back(r);
        bus_data_ok = 1'b1;
        bus_rdata   = d;
    endtask

    grant_t m_g;
    resp_t  m_r;

    always @(negedge clk) begin
        if (bus_req && bus_addr_ok) begin
            if (q_grant.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_grant: got addr %h expected no grant", bus_addr);
            end else begin
                m_g = q_grant.pop_front();
                chk("grant_owner", {inst_sram_addr_ok, data_sram_addr_ok}, m_g.who);
                chk("grant_addr", bus_addr, m_g.addr);
                chk("grant_fields", {bus_size, bus_wr, bus_wstrb, bus_wdata},
                    {m_g.size, m_g.wr, m_g.wstrb, m_g.wdata});
            end
        end else if (inst_sram_addr_ok || data_sram_addr_ok) begin
            chk("addr_ok_without_accept", {inst_sram_addr_ok, data_sram_addr_ok}, 2'b00);
        end
        if (inst_sram_data_ok || data_sram_data_ok) begin
            if (q_resp.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_response: got data_ok %b expected none",
                         {inst_sram_data_ok, data_sram_data_ok});
            end else begin
                m_r = q_resp.pop_front();
                chk("resp_owner", {inst_sram_data_ok, data_sram_data_ok}, m_r.who);
                chk("resp_rdata", inst_sram_data_ok ? inst_sram_rdata : data_sram_rdata, m_r.rdata);
            end
        end
    end

    logic [1:0] rr_seq [4];

    initial begin
`ifdef MEM_ARB_RR_EN
        rr_seq = '{W_DATA, W_INST, W_DATA, W_INST};
`else
        rr_seq = '{W_DATA, W_DATA, W_DATA, W_DATA};
`endif
        // Reset with every input active: all handshakes must stay low.
        reset = 1'b1;
        inst_sram_req = 1'b1; inst_sram_size = 2'd2; inst_sram_addr = 32'h1C00_0000;
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_size = 2'd2;
        data_sram_wstrb = 4'hF; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        tick();
        @(negedge clk);
        chk("reset_outputs", {bus_req, inst_sram_addr_ok, data_sram_addr_ok,
                              inst_sram_data_ok, data_sram_data_ok}, 5'b0);
        chk("reset_rdata", {inst_sram_rdata, data_sram_rdata}, 64'h0);
        tick();
        reset = 1'b0;
        inst_sram_req = 1'b0; data_sram_req = 1'b0; data_sram_wr = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        tick();

        // Inst only
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; bus_addr_ok = 1'b1;
        exp_g(W_INST, 32'h1C00_0000, 1'b0, 4'h0, 32'h0);
        tick();
        inst_sram_req = 1'b0; bus_addr_ok = 1'b0;
        @(negedge clk);
        chk("t1_single_pulse", {bus_req, inst_sram_addr_ok}, 2'b00);
        tick();
        respond(W_INST, 32'h0280_0C0C);
        @(negedge clk);
        chk("t1_no_data_dok", data_sram_data_ok, 1'b0);
        tick();
        bus_data_ok = 1'b0;

        // Contention with fixed priority
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0004;
        data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_wstrb = 4'hF;
        data_sram_addr = 32'h80; data_sram_wdata = 32'h1234_5678; bus_addr_ok = 1'b1;
        exp_g(W_DATA, 32'h80, 1'b1, 4'hF, 32'h1234_5678);
        exp_g(W_INST, 32'h1C00_0004, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t2_bus_wr", bus_wr, 1'b1);
        tick();
        data_sram_req = 1'b0; data_sram_wr = 1'b0;
        tick();
        inst_sram_req = 1'b0; bus_addr_ok = 1'b0;
        tick();
        respond(W_DATA, 32'h0);
        tick();
        respond(W_INST, 32'h29C0_0001);
        tick();
        bus_data_ok = 1'b0;

        // Lock holds INST while addr_ok is withheld
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0100; bus_addr_ok = 1'b0;
        @(negedge clk);
        chk("t3_lock_c0", {bus_req, bus_wr, bus_addr}, {1'b1, 1'b0, 32'h1C00_0100});
        tick();
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_wstrb = 4'h0;
        data_sram_addr = 32'h200; data_sram_wdata = 32'h0;
        @(negedge clk);
        chk("t3_lock_c1", {bus_req, bus_wr, bus_addr}, {1'b1, 1'b0, 32'h1C00_0100});
        tick();
        @(negedge clk);
        chk("t3_lock_c2", {bus_req, bus_wr, bus_addr}, {1'b1, 1'b0, 32'h1C00_0100});
        tick();
        bus_addr_ok = 1'b1;
        exp_g(W_INST, 32'h1C00_0100, 1'b0, 4'h0, 32'h0);
        exp_g(W_DATA, 32'h200, 1'b0, 4'h0, 32'h0);
        tick();
        inst_sram_req = 1'b0;
        tick();
        data_sram_req = 1'b0; bus_addr_ok = 1'b0;
        tick();
        respond(W_INST, 32'h1111_0000);
        tick();
        respond(W_DATA, 32'h2222_0000);
        tick();
        bus_data_ok = 1'b0;

        // Full: four outstanding block the fifth, a pop reopens the next cycle
        inst_sram_req = 1'b1; bus_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_sram_addr = 32'h1C00_0200 + 32'(4 * i);
            exp_g(W_INST, inst_sram_addr, 1'b0, 4'h0, 32'h0);
            tick();
        end
        inst_sram_addr = 32'h1C00_0210;
        respond(W_INST, 32'h3000_0000);
        @(negedge clk);
        chk("t4_full_blocks", {bus_req, inst_sram_addr_ok}, 2'b00);
        tick();
        bus_data_ok = 1'b0;
        exp_g(W_INST, 32'h1C00_0210, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t4_reopen", bus_req, 1'b1);
        tick();
        inst_sram_req = 1'b0; bus_addr_ok = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            respond(W_INST, 32'h3000_0000 + 32'(i));
            tick();
        end
        bus_data_ok = 1'b0;

        // Stray response with nothing outstanding
        bus_data_ok = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("t5_stray", {inst_sram_data_ok, data_sram_data_ok}, 2'b00);
        tick();
        bus_data_ok = 1'b0;
        data_sram_req = 1'b1; data_sram_addr = 32'h300; bus_addr_ok = 1'b1;
        exp_g(W_DATA, 32'h300, 1'b0, 4'h0, 32'h0);
        tick();
        data_sram_req = 1'b0; bus_addr_ok = 1'b0;
        tick();
        respond(W_DATA, 32'h3333_4444);
        tick();
        bus_data_ok = 1'b0;

        // Reset with two DATA outstanding and INST locked
        data_sram_req = 1'b1; data_sram_addr = 32'h500; bus_addr_ok = 1'b1;
        exp_g(W_DATA, 32'h500, 1'b0, 4'h0, 32'h0);
        tick();
        data_sram_addr = 32'h504;
        exp_g(W_DATA, 32'h504, 1'b0, 4'h0, 32'h0);
        tick();
        data_sram_req = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_2000;
        bus_addr_ok = 1'b0;
        @(negedge clk);
        chk("t6_pre_lock", {bus_req, bus_addr}, {1'b1, 32'h1C00_2000});
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_reset_quiet", {bus_req, inst_sram_addr_ok, data_sram_addr_ok}, 3'b000);
        tick();
        reset = 1'b0; inst_sram_req = 1'b0;
        data_sram_req = 1'b1; data_sram_addr = 32'h600; bus_addr_ok = 1'b1;
        exp_g(W_DATA, 32'h600, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t6_fresh_arb", {bus_req, bus_addr}, {1'b1, 32'h600});
        tick();
        data_sram_req = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_2004;
        exp_g(W_INST, 32'h1C00_2004, 1'b0, 4'h0, 32'h0);
        tick();
        inst_sram_req = 1'b0; bus_addr_ok = 1'b0;
        tick();
        respond(W_DATA, 32'h6666_0000);
        tick();
        respond(W_INST, 32'h7777_0000);
        tick();
        bus_data_ok = 1'b0;

        // Continuous contention: DATA priority, or alternation when round-robin
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_1000;
        data_sram_req = 1'b1; data_sram_addr = 32'h400; bus_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g(rr_seq[i], (rr_seq[i] == W_INST) ? 32'h1C00_1000 : 32'h400,
                  1'b0, 4'h0, 32'h0);
        end
        repeat (4) tick();
        inst_sram_req = 1'b0; data_sram_req = 1'b0; bus_addr_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            respond(rr_seq[i], 32'h4000_0000 + 32'(i));
            tick();
        end
        bus_data_ok = 1'b0;

        tick();
        tick();
        chk("grant_queue_drained", 96'(q_grant.size()), 96'h0);
        chk("resp_queue_drained", 96'(q_resp.size()), 96'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
